regfile_mp: RTL and testbench

- Parametrised multi-port register file. Successor to the single-write, dual-read core register file.
- Adds:
  - N read ports and M write ports, with deterministic write-port priority.
  - Same-cycle write-to-read forwarding across all write ports.
  - A per-register busy scoreboard, used by the pipeline hazard unit.
  - A sweep sequencer that zeroes the array after reset or on request.
- Sits in the decode stage. Issue logic drives the scoreboard set port; writeback drives the write ports.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file slice.
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int NR_MAX = 4;
    localparam int NW_MAX = 2;

    // Address width never drops below 1 so a DEPTH of 2 still gets a real index bit.
    function automatic int calc_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage bus of the register file: write/read ports, scoreboard set, clear and ready.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 2,
    parameter int NW    = 1
) ();

    localparam int AW = calc_aw(DEPTH);

    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*W-1:0]  wd;
    logic [NR*AW-1:0] ra;
    logic [NR*W-1:0]  rd;
    logic [NR-1:0]    rbusy;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             clr_req;
    logic             ready;

    modport master (
        output we, wa, wd, ra, sb_set, sb_addr, clr_req,
        input  rd, rbusy, ready
    );

    modport slave (
        input  we, wa, wd, ra, sb_set, sb_addr, clr_req,
        output rd, rbusy, ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for the hazard unit, with NR combinational lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DEPTH    = 32,
    parameter int  NR       = 2,
    parameter int  NW       = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [NW-1:0]    wvalid,
    input  logic [NW*AW-1:0] wa,
    input  logic             set,
    input  logic [AW-1:0]    set_addr,
    input  logic [NR*AW-1:0] ra,
    output logic [NR-1:0]    rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [AW-1:0]    rsel;
    logic             hit;

    // Clears are applied before the set so a newly issued producer wins a same-cycle collision.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else if (en) begin
            for (int k = 0; k < NW; k++) begin
                if (wvalid[k]) begin
                    busy_next[wa[k*AW +: AW]] = 1'b0;
                end
            end
            if (set && !(ZERO_REG != 0 && set_addr == '0)) begin
                busy_next[set_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // A same-cycle writeback to the read address resolves the hazard through forwarding.
    always_comb begin
        rbusy = '0;
        rsel  = '0;
        hit   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rsel = ra[i*AW +: AW];
            hit  = 1'b0;
            for (int k = 0; k < NW; k++) begin
                if (wvalid[k] && wa[k*AW +: AW] == rsel) begin
                    hit = 1'b1;
                end
            end
            rbusy[i] = en && busy[rsel] && !hit && !(ZERO_REG != 0 && rsel == '0);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write forwarding, busy scoreboard and a zeroing sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int AW = calc_aw(DEPTH);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            ready_q;
    logic [W-1:0]    mem [DEPTH];
    logic            in_ready;
    logic            flush;
    logic [NW-1:0]   wvalid;
    logic [NR*W-1:0] rd_mux;
    logic [NR-1:0]   rbusy_sb;
    logic [AW-1:0]   rsel;

    assign in_ready = (state == READY);
    assign flush    = in_ready & bus.clr_req;

    always_comb begin
        wvalid = '0;
        for (int k = 0; k < NW; k++) begin
            wvalid[k] = in_ready && bus.we[k] &&
                        !(ZERO_REG != 0 && bus.wa[k*AW +: AW] == '0);
        end
    end

    // Sweep walks cnt from 0 to DEPTH-1; clr_req during a sweep is deliberately not a restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SWEEP;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr_req) begin
                        state   <= SWEEP;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= SWEEP;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what defines its contents.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[cnt] <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wvalid[k]) begin
                    mem[bus.wa[k*AW +: AW]] <= bus.wd[k*W +: W];
                end
            end
        end
    end

    // Later write ports overwrite earlier ones, giving port NW-1 priority.
    always_comb begin
        rd_mux = '0;
        rsel   = '0;
        for (int i = 0; i < NR; i++) begin
            rsel = bus.ra[i*AW +: AW];
            if (in_ready && !(ZERO_REG != 0 && rsel == '0)) begin
                rd_mux[i*W +: W] = mem[rsel];
                for (int k = 0; k < NW; k++) begin
                    if (wvalid[k] && bus.wa[k*AW +: AW] == rsel) begin
                        rd_mux[i*W +: W] = bus.wd[k*W +: W];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .en       (in_ready),
        .flush    (flush),
        .wvalid   (wvalid),
        .wa       (bus.wa),
        .set      (bus.sb_set),
        .set_addr (bus.sb_addr),
        .ra       (bus.ra),
        .rbusy    (rbusy_sb)
    );

    assign bus.rd    = rd_mux;
    assign bus.rbusy = rbusy_sb;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp: DEPTH=32, two read and two write ports, zero register on.
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    regfile_mp_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();

    regfile_mp #(
        .W        (W),
        .DEPTH    (DEPTH),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return bus.rd[31:0];
            1:       return bus.rd[63:32];
            2:       return {31'b0, bus.rbusy[0]};
            3:       return {31'b0, bus.rbusy[1]};
            default: return {31'b0, bus.ready};
        endcase
    endfunction

    task automatic expectVal(input string tag, input int sel, input logic [31:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    task automatic drainChecks();
        #2;
        while (exp_q.size() > 0) begin
            checkOutput(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic sbs, input logic [4:0] sba, input logic clr);
        @(negedge clk);
        bus.we      = we;
        bus.wa      = {wa1, wa0};
        bus.wd      = {wd1, wd0};
        bus.ra      = {ra1, ra0};
        bus.sb_set  = sbs;
        bus.sb_addr = sba;
        bus.clr_req = clr;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, ra0, ra1, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.we = '0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0; bus.clr_req = 1'b0;

        // Power-on sweep: outputs quiet right after release, ready after exactly 32 edges
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.ra = {5'd6, 5'd5};
        expectVal("post_rst_ready", 4, 32'd0);
        expectVal("post_rst_rd0", 0, 32'd0);
        expectVal("post_rst_rbusy0", 2, 32'd0);
        drainChecks();
        for (int k = 1; k <= 32; k++) begin
            idle(5'd5, 5'd6);
            expectVal($sformatf("sweep_ready_%0d", k), 4, (k == 32) ? 32'd1 : 32'd0);
            if (k == 10) expectVal("sweep_rd0", 0, 32'd0);
            drainChecks();
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            idle(5'(i), 5'(i + 1));
            expectVal($sformatf("zero_r%0d", i), 0, 32'd0);
            expectVal($sformatf("zero_r%0d", i + 1), 1, 32'd0);
            drainChecks();
        end

        // Forwarding through port 0 only, and the hardwired zero register
        applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd4, 1'b0, 5'd0, 1'b0);
        expectVal("fwd_same_cycle", 0, 32'hDEADBEEF);
        expectVal("fwd_other_reg", 1, 32'd0);
        drainChecks();
        idle(5'd5, 5'd5);
        expectVal("fwd_array_p0", 0, 32'hDEADBEEF);
        expectVal("fwd_array_p1", 1, 32'hDEADBEEF);
        drainChecks();
        applyStimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0);
        expectVal("r0_fwd", 0, 32'd0);
        expectVal("r5_hold", 1, 32'hDEADBEEF);
        drainChecks();
        idle(5'd0, 5'd0);
        expectVal("r0_array", 0, 32'd0);
        drainChecks();

        // Write port priority on a shared address
        applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd5, 1'b0, 5'd0, 1'b0);
        expectVal("prio_fwd", 0, 32'h22);
        drainChecks();
        idle(5'd7, 5'd0);
        expectVal("prio_array", 0, 32'h22);
        drainChecks();

        // Scoreboard set, writeback clear, set-beats-clear, zero register never busy
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        expectVal("sb_before_set", 2, 32'd0);
        drainChecks();
        idle(5'd9, 5'd9);
        expectVal("sb_busy_p0", 2, 32'd1);
        expectVal("sb_busy_p1", 3, 32'd1);
        drainChecks();
        applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        expectVal("sb_wb_comb", 2, 32'd0);
        expectVal("sb_wb_data", 0, 32'h99);
        drainChecks();
        idle(5'd9, 5'd9);
        expectVal("sb_cleared", 2, 32'd0);
        drainChecks();
        applyStimulus(2'b01, 5'd9, 32'h9A, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        expectVal("sb_setclr_comb", 2, 32'd0);
        drainChecks();
        idle(5'd9, 5'd9);
        expectVal("sb_set_wins", 2, 32'd1);
        drainChecks();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h9B, 5'd9, 5'd0, 1'b1, 5'd0, 1'b0);
        expectVal("sb_wb_port1", 2, 32'd0);
        expectVal("sb_r0_comb", 3, 32'd0);
        drainChecks();
        idle(5'd9, 5'd0);
        expectVal("sb_port1_cleared", 2, 32'd0);
        expectVal("sb_r0_never_busy", 3, 32'd0);
        expectVal("sb_port1_data", 0, 32'h9B);
        drainChecks();

        // Clear request: r3 filled and busy, then swept; writes and sets during sweep dropped
        applyStimulus(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
        drainChecks();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1);
        expectVal("clr_pre_r3", 0, 32'hA5A5A5A5);
        expectVal("clr_pre_busy", 2, 32'd1);
        expectVal("clr_pre_ready", 4, 32'd1);
        drainChecks();
        for (int k = 0; k <= 32; k++) begin
            if (k == 5)
                applyStimulus(2'b10, 5'd0, 32'h0, 5'd2, 32'hCAFEF00D, 5'd3, 5'd2, 1'b1, 5'd2, 1'b0);
            else if (k == 10)
                applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1);
            else
                idle(5'd3, 5'd2);
            expectVal($sformatf("clr_ready_%0d", k), 4, (k == 32) ? 32'd1 : 32'd0);
            if (k == 0) expectVal("clr_sweep_rd", 0, 32'd0);
            if (k == 32) begin
                expectVal("clr_r3_zero", 0, 32'd0);
                expectVal("clr_r2_dropped", 1, 32'd0);
                expectVal("clr_r3_not_busy", 2, 32'd0);
                expectVal("clr_r2_not_busy", 3, 32'd0);
            end
            drainChecks();
        end

        // Reset at sweep cycle 10 restarts the full 32-cycle sweep
        applyStimulus(2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        drainChecks();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1);
        drainChecks();
        for (int k = 0; k < 10; k++) idle(5'd7, 5'd0);
        rst = 1'b1;
        expectVal("midrst_ready", 4, 32'd0);
        drainChecks();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            idle(5'd7, 5'd0);
            expectVal($sformatf("midrst_ready_%0d", k), 4, (k == 32) ? 32'd1 : 32'd0);
            if (k == 32) expectVal("midrst_r7_zero", 0, 32'd0);
            drainChecks();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
